// File: rtl/brushless_comm.sv
// Six-step BLDC commutation controller: hall sync/filter, dead-time insertion,
// reverse direction, sticky invalid-hall fault and a commutation strobe.
module brushless_comm #(
    parameter int unsigned MAG_W    = 12,
    parameter int unsigned DUTY_W   = 11,
    parameter logic [DUTY_W-1:0] BRK_DUTY = DUTY_W'('h600),
    parameter int unsigned FILT_CYC = 4,
    parameter int unsigned DEAD_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MAG_W-1:0]  drv_mag,
    input  logic              hallGrn,
    input  logic              hallYlw,
    input  logic              hallBlu,
    input  logic              brake_n,
    input  logic              dir_rev,
    input  logic              fault_clr,
    output logic [DUTY_W-1:0] duty,
    output logic [1:0]        selGrn,
    output logic [1:0]        selYlw,
    output logic [1:0]        selBlu,
    output logic              hall_fault,
    output logic              comm_pulse
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0]  FILT_MAX = CNT_W'(FILT_CYC);
    localparam logic [CNT_W-1:0]  DEAD_LD  = CNT_W'(DEAD_CYC);
    localparam logic [DUTY_W-1:0] DUTY_OFS = DUTY_W'(1) << (DUTY_W - 1);

    localparam logic [1:0] SEL_Z = 2'b00;
    localparam logic [1:0] SEL_R = 2'b01;
    localparam logic [1:0] SEL_F = 2'b10;
    localparam logic [1:0] SEL_B = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // A hall code is valid unless all sensors agree (000 or 111).
    function automatic logic code_valid(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    // Reverse direction swaps rising/falling current legs; brake and HI_Z pass through.
    function automatic logic [1:0] swap_dir(input logic [1:0] s);
        case (s)
            SEL_R:   return SEL_F;
            SEL_F:   return SEL_R;
            default: return s;
        endcase
    endfunction

    logic [2:0]        sync1_q, sync1_d;
    logic [2:0]        hall_s_q, hall_s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        hall_acc_q, hall_acc_d;
    logic              acq_q, acq_d;
    logic              hall_fault_q, hall_fault_d;
    logic              comm_pulse_q, comm_pulse_d;
    logic              accept_c;
    logic [5:0]        fwd_c;
    logic [5:0]        target_c;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  dead_cnt_q, dead_cnt_d;
    logic [5:0]        sel_q, sel_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              unused_mag_c;

    // Low magnitude bits below the duty resolution are intentionally dropped.
    assign unused_mag_c = ^drv_mag;

    // Hall synchroniser, stability filter, fault flag and commutation strobe.
    always_comb begin
        sync1_d      = {hallGrn, hallYlw, hallBlu};
        hall_s_d     = sync1_q;
        cnt_d        = cnt_q;
        hall_acc_d   = hall_acc_q;
        acq_d        = acq_q;
        hall_fault_d = hall_fault_q;
        comm_pulse_d = 1'b0;
        accept_c     = (cnt_q == FILT_MAX) && (hall_s_q != hall_acc_q);

        if (hall_s_q != sync1_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != FILT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept_c) begin
            hall_acc_d   = hall_s_q;
            acq_d        = 1'b1;
            comm_pulse_d = code_valid(hall_acc_q) && code_valid(hall_s_q);
        end

        // The reset code 000 only counts as a fault once a code has been accepted.
        if (acq_q && !code_valid(hall_acc_q)) begin
            hall_fault_d = 1'b1;
        end else if (fault_clr && code_valid(hall_acc_q)) begin
            hall_fault_d = 1'b0;
        end
    end

    // Target phase pattern {G,Y,B} from the accepted hall code, brake and direction.
    always_comb begin
        fwd_c = {SEL_Z, SEL_Z, SEL_Z};
        case (hall_acc_q)
            3'b001:  fwd_c = {SEL_Z, SEL_R, SEL_F};
            3'b011:  fwd_c = {SEL_R, SEL_Z, SEL_F};
            3'b010:  fwd_c = {SEL_R, SEL_F, SEL_Z};
            3'b110:  fwd_c = {SEL_Z, SEL_F, SEL_R};
            3'b100:  fwd_c = {SEL_F, SEL_Z, SEL_R};
            3'b101:  fwd_c = {SEL_F, SEL_R, SEL_Z};
            default: fwd_c = {SEL_Z, SEL_Z, SEL_Z};
        endcase

        if (!brake_n) begin
            target_c = {SEL_B, SEL_B, SEL_B};
        end else if (dir_rev) begin
            target_c = {swap_dir(fwd_c[5:4]), swap_dir(fwd_c[3:2]), swap_dir(fwd_c[1:0])};
        end else begin
            target_c = fwd_c;
        end
    end

    // Commutation FSM next state, dead-time counter, select and duty.
    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        sel_d      = sel_q;
        duty_d     = DUTY_OFS + DUTY_W'(drv_mag[MAG_W-1 -: DUTY_W-1]);

        case (state_q)
            ST_RUN: begin
                if (hall_fault_q) begin
                    state_d = ST_FAULT;
                    sel_d   = {SEL_Z, SEL_Z, SEL_Z};
                end else if (target_c != sel_q) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = DEAD_LD;
                    sel_d      = {SEL_Z, SEL_Z, SEL_Z};
                end
            end
            ST_DEAD: begin
                sel_d = {SEL_Z, SEL_Z, SEL_Z};
                if (hall_fault_q) begin
                    state_d = ST_FAULT;
                end else if (dead_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    sel_d   = target_c;
                end else begin
                    dead_cnt_d = dead_cnt_q - CNT_W'(1);
                end
            end
            ST_FAULT: begin
                sel_d = {SEL_Z, SEL_Z, SEL_Z};
                if (!hall_fault_q) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = DEAD_LD;
                end
            end
            default: begin
                state_d    = ST_DEAD;
                dead_cnt_d = DEAD_LD;
                sel_d      = {SEL_Z, SEL_Z, SEL_Z};
            end
        endcase

        if (state_d == ST_FAULT) begin
            duty_d = '0;
        end else if (!brake_n) begin
            duty_d = BRK_DUTY;
        end
    end

    // State registers; reset forces HI_Z, zero duty and a full dead window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 3'b000;
            hall_s_q     <= 3'b000;
            cnt_q        <= CNT_W'(1);
            hall_acc_q   <= 3'b000;
            acq_q        <= 1'b0;
            hall_fault_q <= 1'b0;
            comm_pulse_q <= 1'b0;
            state_q      <= ST_DEAD;
            dead_cnt_q   <= DEAD_LD;
            sel_q        <= {SEL_Z, SEL_Z, SEL_Z};
            duty_q       <= '0;
        end else begin
            sync1_q      <= sync1_d;
            hall_s_q     <= hall_s_d;
            cnt_q        <= cnt_d;
            hall_acc_q   <= hall_acc_d;
            acq_q        <= acq_d;
            hall_fault_q <= hall_fault_d;
            comm_pulse_q <= comm_pulse_d;
            state_q      <= state_d;
            dead_cnt_q   <= dead_cnt_d;
            sel_q        <= sel_d;
            duty_q       <= duty_d;
        end
    end

    assign duty       = duty_q;
    assign selGrn     = sel_q[5:4];
    assign selYlw     = sel_q[3:2];
    assign selBlu     = sel_q[1:0];
    assign hall_fault = hall_fault_q;
    assign comm_pulse = comm_pulse_q;

endmodule

// File: tb/tb_brushless_comm.sv
// Self-checking bench for brushless_comm: vector table plus multi-cycle sequences.
module tb_brushless_comm;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] drv_mag;
    logic [2:0]  hall;
    logic        brake_n;
    logic        dir_rev;
    logic        fault_clr;
    logic [10:0] duty;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic        hall_fault;
    logic        comm_pulse;

    int checks = 0;
    int errors = 0;

    brushless_comm dut (
        .clk        (clk),
        .rst        (rst),
        .drv_mag    (drv_mag),
        .hallGrn    (hall[2]),
        .hallYlw    (hall[1]),
        .hallBlu    (hall[0]),
        .brake_n    (brake_n),
        .dir_rev    (dir_rev),
        .fault_clr  (fault_clr),
        .duty       (duty),
        .selGrn     (selGrn),
        .selYlw     (selYlw),
        .selBlu     (selBlu),
        .hall_fault (hall_fault),
        .comm_pulse (comm_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  sel;
        logic [10:0] duty;
        logic        pulse;
        logic        fault;
    } exp_t;

    typedef struct packed {
        logic [2:0]  hall;
        logic        brk_n;
        logic        rev;
        logic [11:0] mag;
        logic [5:0]  sel;
        logic [10:0] duty;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[10];

    task automatic push_exp(input logic [5:0] s, input logic [10:0] d, input logic p, input logic f);
        exp_t e;
        e.sel = s; e.duty = d; e.pulse = p; e.fault = f;
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        exp_t a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        a.sel = {selGrn, selYlw, selBlu}; a.duty = duty; a.pulse = comm_pulse; a.fault = hall_fault;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got sel=%b duty=%h pulse=%b fault=%b, expected sel=%b duty=%h pulse=%b fault=%b",
                     name, a.sel, a.duty, a.pulse, a.fault, e.sel, e.duty, e.pulse, e.fault);
        end
    endtask

    task automatic wait_pulse(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (comm_pulse === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: comm_pulse timeout, got 0 expected 1", name);
        end
    endtask

    task automatic wait_fault(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (hall_fault === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: hall_fault timeout, got 0 expected 1", name);
        end
    endtask

    // Hall step with a pulse, three HI_Z cycles, then the new pattern.
    task automatic dead_seq(input logic [2:0] h, input logic [5:0] s_old, input logic [5:0] s_new,
                            input logic [10:0] d, input string name);
        bit ok;
        hall = h;
        wait_pulse(name, ok);
        if (ok) begin
            push_exp(s_old, d, 1'b1, 1'b0); check_pop({name, "_pulse"});
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); push_exp(6'b000000, d, 1'b0, 1'b0); check_pop({name, "_dead"});
            end
            @(negedge clk); push_exp(s_new, d, 1'b0, 1'b0); check_pop({name, "_new"});
            @(negedge clk); push_exp(s_new, d, 1'b0, 1'b0); check_pop({name, "_hold"});
        end
    endtask

    initial begin
        bit ok;
        int zc;
        bit seen;

        vt[0] = '{3'b001, 1'b1, 1'b0, 12'hFFC, 6'b000110, 11'h7FF};
        vt[1] = '{3'b011, 1'b1, 1'b0, 12'h000, 6'b010010, 11'h400};
        vt[2] = '{3'b010, 1'b1, 1'b0, 12'h123, 6'b011000, 11'h448};
        vt[3] = '{3'b110, 1'b1, 1'b0, 12'h800, 6'b001001, 11'h600};
        vt[4] = '{3'b100, 1'b1, 1'b0, 12'h7FF, 6'b100001, 11'h5FF};
        vt[5] = '{3'b101, 1'b1, 1'b0, 12'h004, 6'b100100, 11'h401};
        vt[6] = '{3'b101, 1'b1, 1'b1, 12'h004, 6'b011000, 11'h401};
        vt[7] = '{3'b001, 1'b1, 1'b1, 12'hABC, 6'b001001, 11'h6AF};
        vt[8] = '{3'b011, 1'b0, 1'b1, 12'hABC, 6'b111111, 11'h600};
        vt[9] = '{3'b011, 1'b1, 1'b1, 12'h000, 6'b100001, 11'h400};

        rst = 1'b1; hall = 3'b001; brake_n = 1'b1; dir_rev = 1'b0;
        drv_mag = 12'hFFC; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        push_exp(6'b000000, 11'h000, 1'b0, 1'b0); check_pop("reset");
        rst = 1'b0;

        // Startup: HI_Z through filter and dead window, then the 001 pattern.
        zc = 0; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ({selGrn, selYlw, selBlu} != 6'b000000) begin seen = 1'b1; break; end
            zc++;
        end
        checks++;
        if (!seen || zc < 7) begin
            errors++;
            $display("FAIL startup_hiz: got %0d HI_Z cycles (seen=%0b), expected at least 7 then a pattern", zc, seen);
        end
        push_exp(6'b000110, 11'h7FF, 1'b0, 1'b0); check_pop("startup_pattern");

        @(negedge clk);
        dead_seq(3'b011, 6'b000110, 6'b010010, 11'h7FF, "step_fwd");

        hall = 3'b001; dir_rev = 1'b1;
        repeat (20) @(negedge clk);
        push_exp(6'b001001, 11'h7FF, 1'b0, 1'b0); check_pop("rev_settle");
        dead_seq(3'b011, 6'b001001, 6'b100001, 11'h7FF, "step_rev");

        // Short glitches never reach the filter threshold.
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            hall = 3'b010;
            for (int i = 0; i < n; i++) begin
                @(negedge clk); push_exp(6'b100001, 11'h7FF, 1'b0, 1'b0); check_pop("glitch_during");
            end
            hall = 3'b011;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk); push_exp(6'b100001, 11'h7FF, 1'b0, 1'b0); check_pop("glitch_after");
            end
        end

        // Brake apply and release.
        brake_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); push_exp(6'b000000, 11'h600, 1'b0, 1'b0); check_pop("brake_dead");
        end
        @(negedge clk); push_exp(6'b111111, 11'h600, 1'b0, 1'b0); check_pop("brake_on");
        brake_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); push_exp(6'b000000, 11'h7FF, 1'b0, 1'b0); check_pop("release_dead");
        end
        @(negedge clk); push_exp(6'b100001, 11'h7FF, 1'b0, 1'b0); check_pop("release_on");

        // Steady-state vector table.
        for (int v = 0; v < 10; v++) begin
            hall = vt[v].hall; brake_n = vt[v].brk_n; dir_rev = vt[v].rev; drv_mag = vt[v].mag;
            push_exp(vt[v].sel, vt[v].duty, 1'b0, 1'b0);
            repeat (20) @(negedge clk);
            check_pop($sformatf("vec%0d", v));
        end

        // Invalid hall 111: fault, ignored clear, valid code, then clear.
        hall = 3'b111; dir_rev = 1'b0; drv_mag = 12'hFFC;
        wait_fault("fault_set", ok);
        if (ok) begin
            push_exp(6'b000000, 11'h7FF, 1'b0, 1'b1); check_pop("fault_first");
            @(negedge clk); push_exp(6'b000000, 11'h000, 1'b0, 1'b1); check_pop("fault_duty0");
            fault_clr = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); push_exp(6'b000000, 11'h000, 1'b0, 1'b1); check_pop("fault_clr_ignored");
            end
            fault_clr = 1'b0;
            hall = 3'b101;
            repeat (12) @(negedge clk);
            push_exp(6'b000000, 11'h000, 1'b0, 1'b1); check_pop("fault_sticky");
            fault_clr = 1'b1;
            @(negedge clk);
            fault_clr = 1'b0;
            push_exp(6'b000000, 11'h000, 1'b0, 1'b0); check_pop("fault_cleared");
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); push_exp(6'b000000, 11'h7FF, 1'b0, 1'b0); check_pop("fault_dead");
            end
            @(negedge clk); push_exp(6'b100100, 11'h7FF, 1'b0, 1'b0); check_pop("fault_resume");
        end

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 push_exp(6'b000000, 11'h000, 1'b0, 1'b0); check_pop("rst_run");
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
        push_exp(6'b100100, 11'h7FF, 1'b0, 1'b0); check_pop("restart_run");

        // Asynchronous reset during a dead window.
        hall = 3'b100;
        wait_pulse("rst_dead_pulse", ok);
        @(negedge clk);
        push_exp(6'b000000, 11'h7FF, 1'b0, 1'b0); check_pop("in_dead");
        #2 rst = 1'b1;
        #1 push_exp(6'b000000, 11'h000, 1'b0, 1'b0); check_pop("rst_dead");

        // Asynchronous reset clears a latched fault.
        @(negedge clk); rst = 1'b0; hall = 3'b111;
        wait_fault("rst_fault_set", ok);
        #2 rst = 1'b1;
        #1 push_exp(6'b000000, 11'h000, 1'b0, 1'b0); check_pop("rst_fault");
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
